// File: rtl/shaper_pkg.sv
// Shared types and defaults for the trapezoidal shaper sequencing controller.
//   state_t      : controller FSM states
//   shaper_evt_t : peak event payload {peak, tstamp}
//   SHP_DW/SHP_TS_W : default sample and timestamp widths
package shaper_pkg;

  localparam int SHP_DW   = 16;
  localparam int SHP_TS_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WARMUP,
    ST_ARMED,
    ST_PEAK,
    ST_HOLDOFF
  } state_t;

  // peak is a two's-complement value carried as raw bits.
  typedef struct packed {
    logic [SHP_DW-1:0]   peak;
    logic [SHP_TS_W-1:0] tstamp;
  } shaper_evt_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shaper_if.sv
// Peak event valid/ready port between the shaper controller and readout.
//   master: drives ev_valid/ev_peak/ev_time, samples ev_ready
//   slave : the consumer side
interface shaper_ev_if
  import shaper_pkg::*;
#(
  parameter int DW   = SHP_DW,
  parameter int TS_W = SHP_TS_W
);
  logic            ev_valid;
  logic            ev_ready;
  logic [DW-1:0]   ev_peak;
  logic [TS_W-1:0] ev_time;

  modport master (output ev_valid, output ev_peak, output ev_time, input ev_ready);
  modport slave  (input ev_valid, input ev_peak, input ev_time, output ev_ready);
endinterface

// File: rtl/shaper_evt_buf.sv
// One-entry event register with valid/ready output.
//   i_req/i_evt : load request and payload from the peak tracker
//   i_ready     : consumer accepts the held event
//   o_valid/o_evt : held event
//   o_drop      : request lost because the register was full and not draining
module shaper_evt_buf
  import shaper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  shaper_evt_t i_evt,
  input  logic        i_ready,
  output logic        o_valid,
  output shaper_evt_t o_evt,
  output logic        o_drop
);

  logic        r_valid;
  shaper_evt_t r_evt;
  logic        w_drop;

  // A request landing on a draining register replaces the leaving entry.
  assign w_drop = i_req && r_valid && !i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_evt   <= '0;
    end else if (i_req && !w_drop) begin
      r_valid <= 1'b1;
      r_evt   <= i_evt;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_evt   = r_evt;
  assign o_drop  = w_drop;

endmodule

// File: rtl/shaper_ctrl.sv
// Sequencing controller for the trapezoidal shaping filter core.
// Owns the core clear and sample feed, masks the warm-up transient, and runs
// a threshold/peak-capture FSM on the shaped output, emitting timestamped
// peak events to readout.
//   clk, reset        : clock, synchronous active-high reset
//   start, stop       : acquisition control pulses (stop has priority)
//   cfg_threshold     : signed trigger level, latched on start
//   in_valid, in_data : ADC sample stream (continuous while running)
//   flt_rst_n, flt_in : filter core clear (active low) and registered sample
//   flt_out           : signed filter output, two cycles behind flt_in's source
//   busy              : not idle
//   ev                : peak event port {ev_peak, ev_time}
//   err_underrun      : sticky sample-gap flag
//   ovf_cnt           : saturating dropped-event count
module shaper_ctrl
  import shaper_pkg::*;
#(
  parameter int DW        = SHP_DW,
  parameter int TS_W      = SHP_TS_W,
  parameter int FLUSH_CYC = 2,
  parameter int WARMUP    = 12,
  parameter int HOLDOFF   = 32
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] cfg_threshold,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          flt_rst_n,
  output logic [DW-1:0] flt_in,
  input  logic [DW-1:0] flt_out,
  output logic          busy,
  shaper_ev_if.master   ev,
  output logic          err_underrun,
  output logic [7:0]    ovf_cnt
);

  localparam int CNT_MAX = imax(FLUSH_CYC, imax(WARMUP, HOLDOFF));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t          r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]   r_thr, r_pk, r_flt_in;
  logic [TS_W-1:0] r_ts, r_ts_d1, r_ts_d2, r_pk_ts;
  logic            r_err;
  logic [7:0]      r_ovf;

  logic            w_run, w_acc, w_start, w_req, w_drop, w_busy, w_flt_rst_n;
  logic            w_above, w_higher;
  logic            w_ev_valid;
  shaper_evt_t     w_req_evt, w_evt_q;

  assign w_above  = $signed(flt_out) > $signed(r_thr);
  assign w_higher = $signed(flt_out) > $signed(r_pk);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  // ---- next state ----
  always_comb begin
    w_nxt = r_state;
    if (stop) begin
      w_nxt = ST_IDLE;
    end else if (w_run && !in_valid) begin
      w_nxt = ST_FLUSH;                     // underrun: restart the core
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_nxt = ST_FLUSH;
        ST_FLUSH:   if (r_cnt == CNT_W'(FLUSH_CYC - 1)) w_nxt = ST_WARMUP;
        ST_WARMUP:  if (r_cnt == CNT_W'(WARMUP - 1))    w_nxt = ST_ARMED;
        ST_ARMED:   if (w_above)                        w_nxt = ST_PEAK;
        ST_PEAK:    if (!w_above)                       w_nxt = ST_HOLDOFF;
        ST_HOLDOFF: if (r_cnt == CNT_W'(HOLDOFF - 1))   w_nxt = ST_ARMED;
        default:    w_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- outputs / strobes ----
  always_comb begin
    w_run       = r_state inside {ST_WARMUP, ST_ARMED, ST_PEAK, ST_HOLDOFF};
    w_busy      = (r_state != ST_IDLE);
    w_flt_rst_n = w_run;
    w_acc       = w_run && in_valid;
    w_start     = (r_state == ST_IDLE) && start && !stop;
    // Pulse ends on the first sample at or below threshold; the peak so far
    // is the event (the ending sample cannot exceed it).
    w_req       = (r_state == ST_PEAK) && in_valid && !stop && !w_above;
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_thr    <= '0;
      r_pk     <= '0;
      r_pk_ts  <= '0;
      r_flt_in <= '0;
      r_ts     <= '0;
      r_ts_d1  <= '0;
      r_ts_d2  <= '0;
      r_err    <= 1'b0;
      r_ovf    <= '0;
    end else begin
      // flt_out lags the accepted sample by two cycles; so does its index.
      r_ts_d1 <= r_ts;
      r_ts_d2 <= r_ts_d1;

      if (r_state == ST_FLUSH) begin
        r_ts <= '0;
      end else if (w_acc) begin
        r_ts     <= r_ts + 1'b1;
        r_flt_in <= in_data;
      end

      // One counter serves flush cycles, warm-up samples and holdoff samples.
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == ST_FLUSH ||
               (in_valid && (r_state == ST_WARMUP || r_state == ST_HOLDOFF)))
        r_cnt <= r_cnt + 1'b1;

      if (w_start) begin
        r_thr <= cfg_threshold;
        r_err <= 1'b0;
        r_ovf <= '0;
      end else begin
        if (w_run && !in_valid && !stop) r_err <= 1'b1;
        if (w_drop && r_ovf != 8'hFF)    r_ovf <= r_ovf + 1'b1;
      end

      // Strict '>' keeps the earliest sample on a tie.
      if (w_acc && ((r_state == ST_ARMED && w_above) ||
                    (r_state == ST_PEAK  && w_higher))) begin
        r_pk    <= flt_out;
        r_pk_ts <= r_ts_d2;
      end
    end
  end

  assign w_req_evt.peak   = r_pk;
  assign w_req_evt.tstamp = r_pk_ts;

  shaper_evt_buf u_evt_buf (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .i_evt   (w_req_evt),
    .i_ready (ev.ev_ready),
    .o_valid (w_ev_valid),
    .o_evt   (w_evt_q),
    .o_drop  (w_drop)
  );

  assign ev.ev_valid   = w_ev_valid;
  assign ev.ev_peak    = w_evt_q.peak;
  assign ev.ev_time    = w_evt_q.tstamp;

  assign flt_rst_n     = w_flt_rst_n;
  assign flt_in        = r_flt_in;
  assign busy          = w_busy;
  assign err_underrun  = r_err;
  assign ovf_cnt       = r_ovf;

endmodule

// File: tb/tb_shaper_ctrl.sv
// Directed bench for shaper_ctrl: drives the filter output directly and
// checks every cycle against a sample-index based behavioural model, plus
// hand-computed literal expectations at key points.
module tb_shaper_ctrl;
  import shaper_pkg::*;

  localparam int DW = 16, TS_W = 32, FLUSH_CYC = 2, WARMUP = 12, HOLDOFF = 32;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] cfg_threshold = 16'd100, in_data = '0, flt_out = '0;
  logic          flt_rst_n, busy, err_underrun;
  logic [DW-1:0] flt_in;
  logic [7:0]    ovf_cnt;

  shaper_ev_if #(.DW(DW), .TS_W(TS_W)) ev_if();

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  shaper_ctrl #(.DW(DW), .TS_W(TS_W), .FLUSH_CYC(FLUSH_CYC), .WARMUP(WARMUP),
                .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_threshold(cfg_threshold), .in_valid(in_valid), .in_data(in_data),
    .flt_rst_n(flt_rst_n), .flt_in(flt_in), .flt_out(flt_out), .busy(busy),
    .ev(ev_if), .err_underrun(err_underrun), .ovf_cnt(ovf_cnt)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model: phases and sample indices, not FSM states ----
  bit              m_ok = 0, m_on = 0, m_peak = 0, m_evv = 0, m_err = 0;
  int              m_flush = 0, m_thr = 0, m_pk = 0, m_evp = 0, m_ovf = 0;
  longint          m_arm = 0;        // first sample index allowed to trigger
  logic [TS_W-1:0] m_ts = '0, m_d1 = '0, m_d2 = '0, m_pkts = '0, m_evt = '0;
  logic [DW-1:0]   m_fin = '0;

  always @(posedge clk) begin
    int fo;
    bit acc, req, fl;
    fo = $signed(flt_out);
    if (reset) begin
      m_ok = 1; m_on = 0; m_peak = 0; m_evv = 0; m_err = 0; m_flush = 0;
      m_thr = 0; m_pk = 0; m_evp = 0; m_ovf = 0; m_arm = 0;
      m_ts = '0; m_d1 = '0; m_d2 = '0; m_pkts = '0; m_evt = '0; m_fin = '0;
    end else begin
      fl  = m_on && (m_flush > 0);
      acc = m_on && (m_flush == 0) && in_valid;
      req = 0;
      if (stop) m_on = 0;
      else if (!m_on) begin
        if (start) begin
          m_on = 1; m_flush = FLUSH_CYC; m_thr = $signed(cfg_threshold);
          m_err = 0; m_ovf = 0;
        end
      end else if (m_flush > 0) begin
        m_flush--; m_peak = 0; m_arm = WARMUP;
      end else if (!in_valid) begin
        m_err = 1; m_flush = FLUSH_CYC; m_peak = 0;
      end else if (m_peak) begin
        if (fo <= m_thr) begin
          req = 1; m_peak = 0; m_arm = longint'(m_ts) + 1 + HOLDOFF;
        end else if (fo > m_pk) begin
          m_pk = fo; m_pkts = m_d2;
        end
      end else if (longint'(m_ts) >= m_arm && fo > m_thr) begin
        m_peak = 1; m_pk = fo; m_pkts = m_d2;
      end
      if (req) begin
        if (m_evv && !ev_if.ev_ready) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
        else begin m_evv = 1; m_evp = m_pk; m_evt = m_pkts; end
      end else if (m_evv && ev_if.ev_ready) m_evv = 0;
      m_d2 = m_d1; m_d1 = m_ts;
      if (fl) m_ts = '0;
      else if (acc) begin m_ts = m_ts + 1; m_fin = in_data; end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy",         busy,                      m_on);
      chk("flt_rst_n",    flt_rst_n,                 m_on && m_flush == 0);
      chk("flt_in",       flt_in,                    m_fin);
      chk("err_underrun", err_underrun,              m_err);
      chk("ovf_cnt",      ovf_cnt,                   m_ovf);
      chk("ev_valid",     ev_if.ev_valid,            m_evv);
      if (m_evv) begin
        chk("ev_peak",    $signed(ev_if.ev_peak),    m_evp);
        chk("ev_time",    ev_if.ev_time,             m_evt);
      end
    end
  end

  // ---- stimulus ----
  task automatic step();
    @(posedge clk); #1;
    in_data = in_data + 16'd1;
  endtask

  task automatic feed(input int v, input bit rdy = 1'b0);
    flt_out = 16'(v); ev_if.ev_ready = rdy;
    step();
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) feed(0);
  endtask

  task automatic pulse(input int pk, input bit rdy_last = 1'b0);
    feed(150); feed(pk); feed(120); feed(50, rdy_last);
  endtask

  task automatic pulse_a();
    feed(50); feed(150); feed(300); feed(250); feed(90);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nlow;
    ev_if.ev_ready = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);          chk("rst_rstn", flt_rst_n, 0);
    chk("rst_evv", ev_if.ev_valid, 0); chk("rst_ovf", ovf_cnt, 0);
    chk("rst_err", err_underrun, 0);   chk("rst_flt_in", flt_in, 0);
    reset = 1'b0; in_valid = 1'b1;
    step();

    // start, quiet filter: flush exactly two cycles, no events
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", busy, 1);
    nlow = 0;
    for (int i = 0; i < 20; i++) begin
      if (!flt_rst_n) nlow++;
      step();
    end
    chk("rstn_low_cycles", nlow, 2);
    chk("quiet_no_event", ev_if.ev_valid, 0);

    // first pulse: 300 is sample index 18
    pulse_a();
    chk("p1_valid", ev_if.ev_valid, 1);
    chk("p1_peak", $signed(ev_if.ev_peak), 300);
    chk("p1_time", ev_if.ev_time, 18);

    // pulse during holdoff ignored; start while busy ignored
    start = 1'b1; feed(0); start = 1'b0;
    feed(0); feed(0);
    pulse(400);
    chk("hold_peak_kept", $signed(ev_if.ev_peak), 300);
    chk("hold_no_drop", ovf_cnt, 0);
    feed(0, 1'b1);
    chk("p1_consumed", ev_if.ev_valid, 0);
    run(30);
    pulse(400);
    chk("p2_peak", $signed(ev_if.ev_peak), 400);

    // backpressure: 200 held, 300 and 400 dropped
    feed(0, 1'b1);
    run(40); pulse(200);
    run(40); pulse(300);
    run(40); pulse(400);
    chk("bp_peak", $signed(ev_if.ev_peak), 200);
    chk("bp_ovf", ovf_cnt, 2);
    run(40); pulse(500, 1'b1);
    chk("swap_peak", $signed(ev_if.ev_peak), 500);
    chk("swap_ovf", ovf_cnt, 2);

    // underrun in PEAK
    feed(0, 1'b1);
    run(40); feed(150); feed(300);
    in_valid = 1'b0; step(); in_valid = 1'b1;
    chk("ur_err", err_underrun, 1);
    chk("ur_rstn", flt_rst_n, 0);
    chk("ur_no_event", ev_if.ev_valid, 0);
    run(20); pulse_a();
    chk("ur_ts_restart", ev_if.ev_time, 18);

    // stop in PEAK keeps the pending event
    run(40); feed(150); feed(300);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_rstn", flt_rst_n, 0);
    chk("stop_ev_kept", ev_if.ev_valid, 1);
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    chk("stop_wins", busy, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_err_clr", err_underrun, 0);
    chk("restart_ovf_clr", ovf_cnt, 0);
    run(20); pulse_a();
    chk("full_drop_ovf", ovf_cnt, 1);

    // reset in HOLDOFF
    feed(0); feed(0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_busy", busy, 0);
    chk("rst2_rstn", flt_rst_n, 0);
    chk("rst2_evv", ev_if.ev_valid, 0);
    chk("rst2_ovf", ovf_cnt, 0);
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
